// File: rtl/fb_seq_pkg.sv
// Shared definitions for the bunch feedback sequencer: state encoding,
// the DSP add-window length and the default bunch spacing floor.
package fb_seq_pkg;

   localparam int FB_DSP_WINDOW   = 14;
   localparam int MIN_SPACING_DEF = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DELAY  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_GAP    = 3'd3;
   localparam logic [2:0] ST_FLUSH  = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      DELAY  = ST_DELAY,
      STROBE = ST_STROBE,
      GAP    = ST_GAP,
      FLUSH  = ST_FLUSH
   } seq_state_e;

endpackage

// File: rtl/fb_seq_timer.sv
// Loadable down-counter shared by the trigger delay and the inter-bunch gap.
// Load wins over decrement; the count holds once it reaches zero.
module fb_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/fb_bunch_sequencer.sv
// Bunch-train sequencer for the charge*signal feedback DSP stage.
// Optional macro FB_SEQ_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module fb_bunch_sequencer
   import fb_seq_pkg::*;
#(
   parameter int DLY_W       = 16,
   parameter int SPC_W       = 8,
   parameter int NB_W        = 3,
   parameter int MIN_SPACING = MIN_SPACING_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic             cfg_enable,
   input  logic [DLY_W-1:0] cfg_delay,
   input  logic [SPC_W-1:0] cfg_spacing,
   input  logic [NB_W-1:0]  cfg_nbunch,
   output logic             bunch_strb,
   output logic             store_strb,
   output logic             delay_en,
   output logic [NB_W-1:0]  bunch_idx,
   output logic             busy,
`ifdef FB_SEQ_OVERRUN_CNT_EN
   output logic [15:0]      overrun_cnt,
`endif
   output logic             trig_overrun
);

   // The spacing floor must leave room for the full DSP add window.
   localparam int SPACING_FLOOR = (MIN_SPACING > FB_DSP_WINDOW) ? MIN_SPACING : FB_DSP_WINDOW + 1;
   localparam logic [SPC_W-1:0] MIN_SPC = SPC_W'(SPACING_FLOOR);

   seq_state_e       state_q, state_d;
   logic             trig_q;
   logic [SPC_W-1:0] spacing_q, spacing_d;
   logic [NB_W-1:0]  nbunch_q, nbunch_d;
   logic [NB_W-1:0]  idx_q, idx_d;

   logic             bunch_strb_q, bunch_strb_d;
   logic             store_strb_q, store_strb_d;
   logic             delay_en_q, delay_en_d;
   logic [NB_W-1:0]  bunch_idx_q, bunch_idx_d;
   logic             busy_q, busy_d;
   logic             trig_overrun_q, trig_overrun_d;

   logic             trig_event;
   logic             in_train;

   logic             dly_load, dly_dec, dly_zero;
   logic [DLY_W-1:0] dly_load_val, dly_value;
   logic             gap_load, gap_dec, gap_zero;
   logic [SPC_W-1:0] gap_load_val, gap_value;

   fb_seq_timer #(.W(DLY_W)) u_dly_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (dly_load),
      .load_val (dly_load_val),
      .dec      (dly_dec),
      .value    (dly_value),
      .zero     (dly_zero)
   );

   fb_seq_timer #(.W(SPC_W)) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (gap_load),
      .load_val (gap_load_val),
      .dec      (gap_dec),
      .value    (gap_value),
      .zero     (gap_zero)
   );

   assign trig_event = trig & ~trig_q;
   assign dly_dec    = (state_q == DELAY);
   assign gap_dec    = (state_q == GAP);

   // Timers are loaded with N-1 / spacing-2 so that their zero flag marks the
   // last cycle of DELAY / GAP; the state then moves on at the next edge.
   always_comb begin
      state_d      = state_q;
      spacing_d    = spacing_q;
      nbunch_d     = nbunch_q;
      idx_d        = idx_q;
      dly_load     = 1'b0;
      dly_load_val = cfg_delay - DLY_W'(1);
      gap_load     = 1'b0;
      gap_load_val = spacing_q - SPC_W'(2);

      unique case (state_q)
         IDLE: begin
            if (trig_event && cfg_enable) begin
               spacing_d = (cfg_spacing < MIN_SPC) ? MIN_SPC : cfg_spacing;
               nbunch_d  = (cfg_nbunch == '0) ? NB_W'(1) : cfg_nbunch;
               idx_d     = '0;
               if (cfg_delay == '0) begin
                  state_d = STROBE;
               end else begin
                  state_d  = DELAY;
                  dly_load = 1'b1;
               end
            end
         end
         DELAY: begin
            if (dly_zero) begin
               state_d = STROBE;
            end
         end
         STROBE: begin
            state_d  = GAP;
            gap_load = 1'b1;
         end
         GAP: begin
            if (gap_zero) begin
               if (idx_q == nbunch_q - NB_W'(1)) begin
                  state_d = FLUSH;
               end else begin
                  state_d = STROBE;
                  idx_d   = idx_q + NB_W'(1);
               end
            end
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are a registered decode of the current state, one cycle behind it.
   always_comb begin
      in_train       = (state_q == STROBE) || (state_q == GAP);
      bunch_strb_d   = (state_q == STROBE);
      store_strb_d   = in_train;
      delay_en_d     = in_train && (idx_q != '0);
      bunch_idx_d    = in_train ? idx_q : '0;
      busy_d         = (state_q != IDLE);
      trig_overrun_d = trig_event && (state_q != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         trig_q         <= 1'b0;
         spacing_q      <= '0;
         nbunch_q       <= '0;
         idx_q          <= '0;
         bunch_strb_q   <= 1'b0;
         store_strb_q   <= 1'b0;
         delay_en_q     <= 1'b0;
         bunch_idx_q    <= '0;
         busy_q         <= 1'b0;
         trig_overrun_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         trig_q         <= trig;
         spacing_q      <= spacing_d;
         nbunch_q       <= nbunch_d;
         idx_q          <= idx_d;
         bunch_strb_q   <= bunch_strb_d;
         store_strb_q   <= store_strb_d;
         delay_en_q     <= delay_en_d;
         bunch_idx_q    <= bunch_idx_d;
         busy_q         <= busy_d;
         trig_overrun_q <= trig_overrun_d;
      end
   end

   assign bunch_strb   = bunch_strb_q;
   assign store_strb   = store_strb_q;
   assign delay_en     = delay_en_q;
   assign bunch_idx    = bunch_idx_q;
   assign busy         = busy_q;
   assign trig_overrun = trig_overrun_q;

`ifdef FB_SEQ_OVERRUN_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (trig_overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
         ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`endif

   // Timer sanity: the gap count never reaches the spacing, the delay timer idles at zero.
   assert property (@(posedge clk) disable iff (rst) (state_q == GAP) |-> (gap_value < spacing_q));
   assert property (@(posedge clk) disable iff (rst) (state_q != DELAY) |-> (dly_value == '0));

endmodule
